gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
- Parametrised Gray-code counter; successor to the fixed 4-bit up-only Gray counter.
- Adds configurable width, count enable, up/down direction, synchronous parallel load and wrap/saturate mode.
- Adds binary shadow output plus terminal-count and wrap flags.
- Used wherever a single-bit-change count is required: pointer generation, position encoders, low-glitch state indices.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- SATURATE, 0, 0 = wrap at terminal count, 1 = hold at terminal count.
- RESET_VAL, 0, binary value loaded on reset; must be < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; counter steps once per clk edge while high.
- up_dn  input  1  direction; 1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value captured when load = 1.
- gray  output  WIDTH  registered Gray-code count.
- bin  output  WIDTH  registered binary count; always equals gray2bin(gray).
- tc  output  1  terminal count, combinational from bin and up_dn: 1 when (up_dn=1 and bin = all ones) or (up_dn=0 and bin = 0).
- wrap  output  1  registered one-cycle pulse; high in the cycle after a wrapping step.

Behaviour:
- Internal state is a binary register `bin`. `gray` is a separate register loaded with bin2gray(next_bin) on the same edge, so `gray` is glitch-free and never combinational.
- Reset (reset = 0, asynchronous, immediate):
  - bin = RESET_VAL, gray = bin2gray(RESET_VAL), wrap = 0.
  - tc follows its formula from the reset value.
- Release is synchronous in effect: the first step occurs on the first clk edge with reset = 1 and en = 1.
- Priority per rising edge: reset > load > en > hold.
- load = 1:
  - bin <= load_val, gray <= bin2gray(load_val), wrap <= 0.
  - en and up_dn are ignored that cycle.
- en = 1, load = 0:
  - up_dn = 1: bin <= bin + 1 modulo 2**WIDTH.
  - up_dn = 0: bin <= bin - 1 modulo 2**WIDTH.
- Terminal-count step (en = 1, load = 0, tc = 1):
  - SATURATE = 0: counter wraps (all ones -> 0 up, 0 -> all ones down); wrap <= 1 for exactly one cycle.
  - SATURATE = 1: bin and gray hold; wrap stays 0.
- en = 0, load = 0: bin and gray hold; wrap <= 0.
- Latency: one clk edge from en/load sampling to a new gray/bin value.
- Invariant: every enabled non-load step changes exactly one bit of gray, including the wrap step in both directions.
- A direction change between cycles is legal and takes effect on the next step; the single-bit-change invariant still holds.
- Loaded values are not required to satisfy the single-bit-change invariant relative to the previous value.
- Reset asserted mid-count: outputs go to reset values immediately, independent of clk.
- No X-propagation: all flops are reset.

Decomposition:
- Shared package `gray_pkg`: functions bin2gray(b) = b ^ (b >> 1) and gray2bin (XOR prefix from MSB), both parametrised on WIDTH via the caller's width.
- One natural combinational sub-module, `gray_conv`: WIDTH parameter, bin in, gray out. It is reused by the future Gray-pointer FIFO; the counter instantiates it for next-state Gray generation.
- Everything else stays in gray_counter_param.

Test Plan:
- WIDTH=4, SATURATE=0, reset pulse, then en=1, up_dn=1 for 16 clk edges -> gray = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000. wrap high exactly one cycle after the 1000 -> 0000 step; tc = 1 while gray = 1000.
- Count down from reset value 0 with en=1, up_dn=0 -> first step gives bin = 15, gray = 1000, wrap pulses once. Next steps give gray 1001 (bin 14), 1011 (bin 13).
- load=1, load_val=10 with en=1 in the same cycle -> bin = 10, gray = 1111, wrap = 0. Then en=1, up_dn=1 gives bin = 11, gray = 1110.
- SATURATE=1, load_val=14, up_dn=1, en=1 for 4 edges -> bin = 15 (gray 1000) and holds; wrap never asserts; tc stays 1.
- en toggled 0/1 randomly over 200 cycles -> gray holds when en=0; every enabled step differs in exactly 1 bit; bin always equals gray2bin(gray).
- Async reset: drive reset=0 mid-clock-period while at bin = 9 -> gray = 0000 and bin = 0 before the next clk edge. Repeat with RESET_VAL=5 -> gray = 0111.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for counters and Gray-pointer FIFOs.
// Functions work on a 16-bit word; callers zero-extend in and truncate back to their own width.
package gray_pkg;
  localparam int GRAY_MAX_W = 16;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits do not change the prefix XOR, so any narrower width decodes correctly.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

// File: rtl/gray_conv.sv
// Combinational binary-to-Gray converter of configurable width.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(gray_word_t'(bin_i)));

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray-code counter with load, wrap/saturate mode, binary shadow and wrap/terminal flags.
// Gray output is its own register fed from the next binary state, so it never glitches.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(gray_word_t'(RST_BIN)));

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             tc_w;

  assign tc_w = up_dn ? (&bin_q) : ~(|bin_q);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      // At terminal count a saturating counter simply holds; otherwise the modulo step wraps.
      if (!(tc_w && (SATURATE != 0))) begin
        bin_d  = up_dn ? (bin_q + ONE) : (bin_q - ONE);
        wrap_d = tc_w;
      end
    end
  end

  gray_conv #(
    .WIDTH(WIDTH)
  ) u_gray_conv (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_w;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: wrap, saturate and non-zero reset-value instances.
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] gray_a, bin_a, gray_s, bin_s, gray_r, bin_r;
  logic       tc_a, wrap_a, tc_s, wrap_s, tc_r, wrap_r;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray(gray_a), .bin(bin_a), .tc(tc_a), .wrap(wrap_a)
  );

  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray(gray_s), .bin(bin_s), .tc(tc_s), .wrap(wrap_s)
  );

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(5)) u_rv5 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray(gray_r), .bin(bin_r), .tc(tc_r), .wrap(wrap_r)
  );

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gtab [16];
  logic [3:0] prev_g;
  logic [3:0] m;
  logic [3:0] exp_g;
  logic [3:0] hd;
  logic       e, d;

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    #12;
    chk4("rst_gray", gray_a, 4'b0000);
    chk4("rst_bin", bin_a, 4'd0);
    chk1("rst_wrap", wrap_a, 1'b0);
    chk1("rst_tc_up", tc_a, 1'b0);
    chk4("rst5_gray", gray_r, 4'b0111);
    chk4("rst5_bin", bin_r, 4'd5);
    up_dn = 1'b0;
    #1;
    chk1("rst_tc_dn", tc_a, 1'b1);

    // Full up-count cycle through the wrap.
    reset = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      prev_g = gray_a;
      step();
      chk4($sformatf("up_gray_%0d", k), gray_a, gtab[k % 16]);
      chk4($sformatf("up_bin_%0d", k), bin_a, 4'(k % 16));
      chk1($sformatf("up_wrap_%0d", k), wrap_a, (k == 16));
      chk1($sformatf("up_tc_%0d", k), tc_a, (k == 15));
      hd = 4'($countones(gray_a ^ prev_g));
      chk4($sformatf("up_1bit_%0d", k), hd, 4'd1);
    end

    // Down count from reset value 0.
    reset = 1'b0;
    #1;
    reset = 1'b1; up_dn = 1'b0; en = 1'b1;
    step();
    chk4("dn1_bin", bin_a, 4'd15);
    chk4("dn1_gray", gray_a, 4'b1000);
    chk1("dn1_wrap", wrap_a, 1'b1);
    step();
    chk4("dn2_bin", bin_a, 4'd14);
    chk4("dn2_gray", gray_a, 4'b1001);
    chk1("dn2_wrap", wrap_a, 1'b0);
    step();
    chk4("dn3_bin", bin_a, 4'd13);
    chk4("dn3_gray", gray_a, 4'b1011);

    // Load wins over enable.
    load = 1'b1; load_val = 4'd10;
    step();
    chk4("ld_bin", bin_a, 4'd10);
    chk4("ld_gray", gray_a, 4'b1111);
    chk1("ld_wrap", wrap_a, 1'b0);
    load = 1'b0; up_dn = 1'b1;
    step();
    chk4("ld_next_bin", bin_a, 4'd11);
    chk4("ld_next_gray", gray_a, 4'b1110);

    // Saturating instance from 14 upward.
    load = 1'b1; load_val = 4'd14;
    step();
    chk4("sat_ld_bin", bin_s, 4'd14);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk4($sformatf("sat_bin_%0d", k), bin_s, 4'd15);
      chk4($sformatf("sat_gray_%0d", k), gray_s, 4'b1000);
      chk1($sformatf("sat_wrap_%0d", k), wrap_s, 1'b0);
      chk1($sformatf("sat_tc_%0d", k), tc_s, 1'b1);
    end
    // Wrapping instance followed the same inputs: 14 -> 15 -> 0 -> 1 -> 2.
    chk4("wrap_after_sat_bin", bin_a, 4'd2);

    en = 1'b0;
    step();
    chk4("hold_bin", bin_a, 4'd2);
    chk4("hold_gray", gray_a, 4'b0011);
    chk1("hold_wrap", wrap_a, 1'b0);

    // Random enable and direction.
    m = 4'd2;
    for (int k = 0; k < 200; k++) begin
      e = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      en = e; up_dn = d;
      prev_g = gray_a;
      step();
      if (e) m = d ? (m + 4'd1) : (m - 4'd1);
      exp_g = m ^ {1'b0, m[3:1]};
      chk4($sformatf("rnd_bin_%0d", k), bin_a, m);
      chk4($sformatf("rnd_gray_%0d", k), gray_a, exp_g);
      hd = 4'($countones(gray_a ^ prev_g));
      chk4($sformatf("rnd_1bit_%0d", k), hd, e ? 4'd1 : 4'd0);
    end

    // Asynchronous reset mid-period.
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    chk4("pre_arst_bin", bin_a, 4'd9);
    chk4("pre_arst_bin5", bin_r, 4'd9);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk4("arst_gray", gray_a, 4'b0000);
    chk4("arst_bin", bin_a, 4'd0);
    chk1("arst_wrap", wrap_a, 1'b0);
    chk4("arst5_gray", gray_r, 4'b0111);
    chk4("arst5_bin", bin_r, 4'd5);
    en = 1'b1;
    step();
    chk4("arst_held_bin", bin_a, 4'd0);
    reset = 1'b1;
    step();
    chk4("arst_rel_bin", bin_a, 4'd1);
    chk4("arst_rel5_bin", bin_r, 4'd6);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
